// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin arbiter that shares one external pipelined
// signed multiplier among NREQ requesters. The granted requester's operands are
// registered onto mul_a/mul_b. A {valid, id} tag pipeline of depth LAT follows
// each operation to the multiplier output. When the product emerges, it is
// returned together with the originating requester index.
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int LAT  = 3,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*W-1:0]     req_a,
    input  logic [NREQ*W-1:0]     req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [W-1:0]          mul_a,
    output logic [W-1:0]          mul_b,
    input  logic [2*W-1:0]        mul_y,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*W-1:0]        rsp_y,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    logic [IDW-1:0]   ptr_r;
    logic [NREQ-1:0]  rot_s;
    logic [NREQ-1:0]  grant_s;
    logic             found_s;
    int               gnt_sum_s;
    int               nxt_sum_s;
    logic [IDW-1:0]   gnt_id_s;
    logic [IDW-1:0]   ptr_nxt_s;
    logic             hs_s;
    logic [W-1:0]     sel_a_s;
    logic [W-1:0]     sel_b_s;

    logic [W-1:0]     mul_a_r;
    logic [W-1:0]     mul_b_r;
    logic             issue_v_r;
    logic [IDW-1:0]   issue_id_r;
    logic [LAT-1:0]   tag_v_r;
    logic [IDW-1:0]   tag_id_r [LAT];
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [2*W-1:0]   rsp_y_r;
    logic [15:0]      done_cnt_r;

    // Round-robin search: rotate requests so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_s     = NREQ'({req_valid, req_valid} >> ptr_r);
        found_s   = 1'b0;
        gnt_sum_s = 0;
        nxt_sum_s = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found_s && rot_s[j]) begin
                found_s   = 1'b1;
                gnt_sum_s = int'(ptr_r) + j;
            end else begin
                gnt_sum_s = gnt_sum_s;
            end
        end
        if (gnt_sum_s >= NREQ) begin
            gnt_sum_s = gnt_sum_s - NREQ;
        end else begin
            gnt_sum_s = gnt_sum_s;
        end
        nxt_sum_s = gnt_sum_s + 1;
        if (nxt_sum_s >= NREQ) begin
            nxt_sum_s = 0;
        end else begin
            nxt_sum_s = nxt_sum_s;
        end
        gnt_id_s  = IDW'(gnt_sum_s);
        ptr_nxt_s = IDW'(nxt_sum_s);
        // Grants are suppressed while disabled or held in reset.
        if (found_s && en && !rst) begin
            grant_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_s;
        end else begin
            grant_s = '0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id_s == IDW'(i)) begin
                sel_a_s = req_a[i*W +: W];
                sel_b_s = req_b[i*W +: W];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    assign hs_s      = |grant_s;
    assign req_ready = grant_s;

    // Round-robin pointer advances past the granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Issue register; idle cycles present zero operands to the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r    <= '0;
            mul_b_r    <= '0;
            issue_v_r  <= 1'b0;
            issue_id_r <= '0;
        end else if (hs_s) begin
            mul_a_r    <= sel_a_s;
            mul_b_r    <= sel_b_s;
            issue_v_r  <= 1'b1;
            issue_id_r <= gnt_id_s;
        end else begin
            mul_a_r    <= '0;
            mul_b_r    <= '0;
            issue_v_r  <= 1'b0;
            issue_id_r <= '0;
        end
    end

    // Tag pipeline tracks each operation through the multiplier latency; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_v_r[0]  <= issue_v_r;
            tag_id_r[0] <= issue_id_r;
            for (int k = 1; k < LAT; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    // Response register and completion counter; id/product hold between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_y_r     <= '0;
            done_cnt_r  <= 16'd0;
        end else if (tag_v_r[LAT-1]) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= tag_id_r[LAT-1];
            rsp_y_r     <= mul_y;
            done_cnt_r  <= done_cnt_r + 16'd1;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= rsp_id_r;
            rsp_y_r     <= rsp_y_r;
            done_cnt_r  <= done_cnt_r;
        end
    end

    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_y     = rsp_y_r;
    assign done_cnt  = done_cnt_r;
    assign busy      = issue_v_r | (|tag_v_r);

endmodule
